// File: rtl/hanoi_move_gen.sv
// Iterative Towers of Hanoi solver: emits the 2^N-1 optimal moves (rod 0 -> rod 2) as fr/to/disk
// over a valid/ready handshake. Optional legality checker enabled by macro HANOI_LEGAL_CHK_EN.
module hanoi_move_gen #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   output logic         move_valid,
   input  logic         move_ready,
   output logic [1:0]   fr,
   output logic [1:0]   to,
   output logic [2:0]   disk,
   output logic [N-1:0] move_cnt,
   output logic         busy,
   output logic         done,
   output logic         err
);

   // Handshake: a move transfers on any rising edge where move_valid && move_ready;
   // while move_valid is high and move_ready is low, fr/to/disk are held stable.

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      OFFER = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [N-1:0] LAST_CNT = '1;
   localparam bit           N_EVEN   = (N % 2 == 0);

   state_t state;
   state_t state_next;

   logic [N-1:0][1:0] pos;
   logic [N-1:0]      cnt_inc;
   logic [1:0]        calc_fr;
   logic [1:0]        calc_to;
   logic [2:0]        calc_disk;
   logic [1:0]        rod_a;
   logic [1:0]        rod_b;
   logic [3:0]        top_a;
   logic [3:0]        top_b;

   // Smallest disk sitting on rod r, or N when the rod is empty.
   function automatic logic [3:0] top_of(input logic [N-1:0][1:0] p, input logic [1:0] r);
      logic [3:0] t;
      t = 4'(N);
      for (int i = N - 1; i >= 0; i--) begin
         if (p[i] == r) t = 4'(i);
      end
      return t;
   endfunction

   function automatic logic [1:0] rod_add(input logic [1:0] r, input logic [1:0] d);
      logic [2:0] s;
      s = {1'b0, r} + {1'b0, d};
      if (s >= 3'd3) s = s - 3'd3;
      return s[1:0];
   endfunction

   assign cnt_inc = move_cnt + 1'b1;

   // Odd move number (move_cnt even) cycles disk 0; otherwise the single legal move between the other rods.
   always_comb begin
      rod_a     = rod_add(pos[0], 2'd1);
      rod_b     = rod_add(pos[0], 2'd2);
      top_a     = top_of(pos, rod_a);
      top_b     = top_of(pos, rod_b);
      calc_fr   = pos[0];
      calc_to   = N_EVEN ? rod_a : rod_b;
      calc_disk = 3'd0;
      if (move_cnt[0]) begin
         if (top_a < top_b) begin
            calc_fr   = rod_a;
            calc_to   = rod_b;
            calc_disk = top_a[2:0];
         end else begin
            calc_fr   = rod_b;
            calc_to   = rod_a;
            calc_disk = top_b[2:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      move_valid = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_next = CALC;
         end
         CALC: begin
            busy       = 1'b1;
            state_next = OFFER;
         end
         OFFER: begin
            busy       = 1'b1;
            move_valid = 1'b1;
            if (move_ready) state_next = (cnt_inc == LAST_CNT) ? DONE : CALC;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pos      <= '0;
         fr       <= 2'd0;
         to       <= 2'd0;
         disk     <= 3'd0;
         move_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  pos      <= '0;
                  move_cnt <= '0;
               end
            end
            CALC: begin
               fr   <= calc_fr;
               to   <= calc_to;
               disk <= calc_disk;
            end
            OFFER: begin
               if (move_ready) begin
                  for (int i = 0; i < N; i++) begin
                     if (disk == 3'(i)) pos[i] <= to;
                  end
                  move_cnt <= cnt_inc;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef HANOI_LEGAL_CHK_EN
   logic [3:0] top_fr;
   logic [3:0] top_to;
   logic       bad;

   // Checks the offered move against the live rod state, and the final tower placement in DONE.
   always_comb begin
      top_fr = top_of(pos, fr);
      top_to = top_of(pos, to);
      bad    = 1'b0;
      if (state == OFFER) begin
         if ((fr == to) || (fr == 2'd3) || (to == 2'd3) ||
             ({1'b0, disk} != top_fr) || (top_to < {1'b0, disk}))
            bad = 1'b1;
      end
      if ((state == DONE) && (pos != {N{2'b10}})) bad = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)      err <= 1'b0;
      else if (bad) err <= 1'b1;
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_hanoi_move_gen.sv
// Directed bench for hanoi_move_gen: N=4 and N=3 instances, table-driven move sequences
// plus stall, mid-solve reset, start-while-busy and (with HANOI_LEGAL_CHK_EN) checker cases.
module tb_hanoi_move_gen;

   typedef struct packed {
      logic [1:0] fr;
      logic [1:0] to;
      logic [2:0] disk;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       move_ready = 1'b1;
   logic       move_valid;
   logic [1:0] fr;
   logic [1:0] to;
   logic [2:0] disk;
   logic [3:0] move_cnt;
   logic       busy;
   logic       done;
   logic       err;

   logic       start3 = 1'b0;
   logic       ready3 = 1'b1;
   logic       valid3;
   logic [1:0] fr3;
   logic [1:0] to3;
   logic [2:0] disk3;
   logic [2:0] cnt3;
   logic       busy3;
   logic       done3;
   logic       err3;

   int checks_total = 0;
   int checks_pass  = 0;

   vec_t       tab4 [15];
   vec_t       tab3 [7];
   logic [6:0] exp_q [$];

   hanoi_move_gen #(.N(4)) dut (
      .clk(clk), .rst(rst), .start(start), .move_valid(move_valid), .move_ready(move_ready),
      .fr(fr), .to(to), .disk(disk), .move_cnt(move_cnt), .busy(busy), .done(done), .err(err)
   );

   hanoi_move_gen #(.N(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .move_valid(valid3), .move_ready(ready3),
      .fr(fr3), .to(to3), .disk(disk3), .move_cnt(cnt3), .busy(busy3), .done(done3), .err(err3)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks_total++;
      if (act === expv) checks_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (move_valid) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_busy", busy, 1'b1);
      check("start_calc_no_valid", move_valid, 1'b0);
      @(negedge clk);
      check("start_valid_t2", move_valid, 1'b1);
   endtask

   // Full N=4 solve; optional stall on one move, restart attempt while busy, or early stop.
   task automatic run_n4(input int stall_idx, input int busy_start_idx, input int stop_after);
      bit   ok;
      bit   finished;
      logic [6:0] e;
      finished = 1'b1;
      exp_q.delete();
      for (int i = 0; i < 15; i++) exp_q.push_back(tab4[i]);
      move_ready = 1'b1;
      pulse_start();
      for (int i = 0; i < 15; i++) begin
         if (i == stop_after) begin
            finished = 1'b0;
            break;
         end
         wait_valid(ok);
         if (!ok) begin
            check("valid_timeout", 32'd0, 32'd1);
            finished = 1'b0;
            break;
         end
         e = exp_q.pop_front();
         check($sformatf("move%0d", i + 1), {fr, to, disk}, e);
         check($sformatf("cnt_at_move%0d", i + 1), move_cnt, i);
         if (i == stall_idx) begin
            move_ready = 1'b0;
            for (int j = 1; j <= 5; j++) begin
               @(negedge clk);
               check("stall_valid", move_valid, 1'b1);
               check("stall_fields", {fr, to, disk}, e);
            end
            check("stall_cnt", move_cnt, i);
            move_ready = 1'b1;
         end
         if (i == busy_start_idx) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      if (finished) begin
         check("done_pulse", done, 1'b1);
         check("done_no_valid", move_valid, 1'b0);
         @(negedge clk);
         check("done_one_cycle", done, 1'b0);
         check("idle_not_busy", busy, 1'b0);
         check("final_cnt", move_cnt, 4'd15);
         check("final_pos", dut.pos, 8'b10_10_10_10);
         check("err_clear", err, 1'b0);
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("idle_quiet", {move_valid, done}, 2'b00);
         end
      end
   endtask

   initial begin
      bit   ok;
      logic [6:0] e;

      tab4[0]  = '{2'd0, 2'd1, 3'd0};  tab4[1]  = '{2'd0, 2'd2, 3'd1};
      tab4[2]  = '{2'd1, 2'd2, 3'd0};  tab4[3]  = '{2'd0, 2'd1, 3'd2};
      tab4[4]  = '{2'd2, 2'd0, 3'd0};  tab4[5]  = '{2'd2, 2'd1, 3'd1};
      tab4[6]  = '{2'd0, 2'd1, 3'd0};  tab4[7]  = '{2'd0, 2'd2, 3'd3};
      tab4[8]  = '{2'd1, 2'd2, 3'd0};  tab4[9]  = '{2'd1, 2'd0, 3'd1};
      tab4[10] = '{2'd2, 2'd0, 3'd0};  tab4[11] = '{2'd1, 2'd2, 3'd2};
      tab4[12] = '{2'd0, 2'd1, 3'd0};  tab4[13] = '{2'd0, 2'd2, 3'd1};
      tab4[14] = '{2'd1, 2'd2, 3'd0};

      tab3[0] = '{2'd0, 2'd2, 3'd0};  tab3[1] = '{2'd0, 2'd1, 3'd1};
      tab3[2] = '{2'd2, 2'd1, 3'd0};  tab3[3] = '{2'd0, 2'd2, 3'd2};
      tab3[4] = '{2'd1, 2'd0, 3'd0};  tab3[5] = '{2'd1, 2'd2, 3'd1};
      tab3[6] = '{2'd0, 2'd2, 3'd0};

      repeat (3) @(negedge clk);
      check("rst_valid", move_valid, 1'b0);
      check("rst_fr_to_disk", {fr, to, disk}, 7'd0);
      check("rst_cnt", move_cnt, 4'd0);
      check("rst_busy_done_err", {busy, done, err}, 3'b000);
      check("rst_pos", dut.pos, 8'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_no_busy", busy, 1'b0);

      // plain run, ready held high
      run_n4(-1, -1, 99);
      // stall 5 cycles on the third move
      run_n4(2, -1, 99);
      // start pulsed while busy is ignored
      run_n4(-1, 5, 99);

      // reset after 6 accepts, then a fresh solve
      run_n4(-1, -1, 6);
      check("pre_rst_cnt", move_cnt, 4'd6);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_valid", move_valid, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_cnt", move_cnt, 4'd0);
      repeat (3) @(negedge clk);
      check("midrst_stays_idle", {move_valid, busy}, 2'b00);
      run_n4(-1, -1, 99);

      // N=3 instance
      exp_q.delete();
      for (int i = 0; i < 7; i++) exp_q.push_back(tab3[i]);
      start3 = 1'b1;
      @(negedge clk);
      start3 = 1'b0;
      for (int i = 0; i < 7; i++) begin
         ok = 1'b0;
         for (int c = 0; c < 10; c++) begin
            if (valid3) begin
               ok = 1'b1;
               break;
            end
            @(negedge clk);
         end
         if (!ok) begin
            check("n3_valid_timeout", 32'd0, 32'd1);
            break;
         end
         e = exp_q.pop_front();
         check($sformatf("n3_move%0d", i + 1), {fr3, to3, disk3}, e);
         @(negedge clk);
      end
      check("n3_done", done3, 1'b1);
      check("n3_cnt", cnt3, 3'd7);
      @(negedge clk);
      check("n3_done_once", {done3, busy3}, 2'b00);
      check("n3_pos", dut3.pos, 6'b10_10_10);
      check("n3_err", err3, 1'b0);

`ifdef HANOI_LEGAL_CHK_EN
      begin
         logic [3:0][1:0] pv;
         move_ready = 1'b1;
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         for (int i = 0; i < 2; i++) begin
            wait_valid(ok);
            @(negedge clk);
         end
         move_ready = 1'b0;
         wait_valid(ok);
         check("chk_third_move", {fr, to, disk}, {2'd1, 2'd2, 3'd0});
         check("chk_err_before", err, 1'b0);
         pv = dut.pos;
         pv[0] = 2'd2;
         force dut.pos = pv;
         @(negedge clk);
         release dut.pos;
         @(negedge clk);
         check("chk_err_set", err, 1'b1);
         move_ready = 1'b1;
         repeat (6) @(negedge clk);
         check("chk_err_sticky", err, 1'b1);
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         check("chk_err_rst", err, 1'b0);
      end
`endif

      $display("%0d/%0d checks passed", checks_pass, checks_total);
      $finish;
   end

endmodule
